wb_regfile: RTL and testbench
=============================

# wb_regfile

Write-back stage and general register file for the pipelined CPU. It consumes the registered outputs of the EX/WB pipeline buffer and selects the write-back value from the saved PC, the memory read data or the ALU result. It commits that value to a 64-entry register file and serves two combinational read ports to the decode stage, with same-cycle write-through bypass. It also keeps a retired-write counter for performance monitoring.

## Interface
Parameters:
- DATA_WIDTH, 32, register and data-path width
- ADDR_WIDTH, 6, register index width; the file holds 2**ADDR_WIDTH = 64 entries

Ports:
- clock  input  1  single clock for all state
- reset  input  1  synchronous, active-high; sampled on the rising edge of clock
- regWrite  input  1  write enable, from the EX/WB buffer
- WAI  input  1  write-address-instruction select: the write value is PC
- memRead  input  1  load select: the write value is readData
- PC  input  DATA_WIDTH  saved PC value, from the EX/WB buffer
- readData  input  DATA_WIDTH  data memory read value
- ALUResult  input  DATA_WIDTH  ALU output
- rd  input  ADDR_WIDTH  destination register index
- rs  input  ADDR_WIDTH  read port A index, from decode
- rt  input  ADDR_WIDTH  read port B index, from decode
- out_rsData  output  DATA_WIDTH  read port A data
- out_rtData  output  DATA_WIDTH  read port B data
- out_wbData  output  DATA_WIDTH  selected write-back value (combinational, for forwarding)
- wb_count  output  32  number of committed register writes

## Operation
- Write-back select, combinational, in fixed priority:
  - WAI=1 gives PC.
  - Otherwise memRead=1 gives readData.
  - Otherwise the value is ALUResult.
  - WAI and memRead both 1 gives PC.
- Commit: on the rising edge of clock, with reset=0 and regWrite=1, regs[rd] takes out_wbData. All 64 entries are writable; there is no hard-wired zero register.
- regWrite=0: no register changes and wb_count holds, whatever the values of WAI, memRead and rd.
- Read ports are combinational:
  - out_rsData = regs[rs], except when regWrite=1 and rs==rd, in which case it is out_wbData (write-through bypass).
  - out_rtData follows the same rule with rt.
  - Both ports may address the same register, including rd, in the same cycle.
- wb_count increments by 1 on every committed write and wraps from 0xFFFFFFFF to 0.
- Reset:
  - All 64 registers and wb_count clear to 0 at the rising edge of clock while reset=1.
  - Reset has priority: a write presented in the same cycle is discarded.
  - After release, the read outputs show 0 unless the bypass is active. out_wbData is never reset, because it is combinational.
- Unknown or X on rd while regWrite=0 must not corrupt any register.

## Timing
- The EX/WB buffer updates on the falling edge of clock. This block commits on the rising edge, giving half a cycle of input settling.
- Write latency: a value presented with regWrite=1 is visible on the read ports in the same cycle through the bypass. It is visible through the array from the cycle after the rising edge.
- Read latency is 0 cycles; there is no read handshake.
- wb_count reflects a write one rising edge after that write is presented.
- Simultaneous events: one write and two reads per cycle. The bypass makes read-after-write within a cycle return the new value.

## Structure
- Shared package cpu_pkg holds:
  - DATA_WIDTH and ADDR_WIDTH defaults.
  - NUM_REGS = 64.
  - A wb_src enum {WB_ALU, WB_MEM, WB_PC} used by the select logic.
- One sub-module, regfile: the 64 x DATA_WIDTH array with synchronous reset, one write port and two raw combinational read ports.
- The top level contains the select mux, the bypass comparators and wb_count.

## Test plan
- Reset with all registers pre-written to nonzero values: hold reset for 1 cycle, then read r0..r63 → every read returns 0 and wb_count=0.
- ALU write: regWrite=1, WAI=0, memRead=0, rd=5, ALUResult=0x0000_1234, rs=5 in the same cycle → out_rsData=0x1234 (bypass). After the edge, with regWrite=0 and rs=5 → 0x1234; wb_count=1.
- Select priority, rd=9 with PC=0xAAAA_0000, readData=0x5555_0000, ALUResult=0x0F0F_0F0F:
  - WAI=1, memRead=1 → r9=0xAAAA_0000.
  - WAI=0, memRead=1 → r9=0x5555_0000.
- Write disabled: regWrite=0, rd=9, ALUResult=0xDEAD_BEEF → r9 and wb_count unchanged.
- Reset collision: reset=1 and regWrite=1 with rd=3, ALUResult=7 in the same cycle → r3=0 and wb_count=0 afterwards.
- Counter wrap: preload wb_count to 0xFFFF_FFFE, then commit 2 writes → wb_count=0. Also set rs=rt=rd=63 during a write of 0x1 → both read ports return 0x1.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared CPU definitions for the write-back / register-file
//               slice: default widths, register count and the write-back
//               source encoding with its priority decode.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int c_DATA_WIDTH = 32;
    localparam int c_ADDR_WIDTH = 6;
    localparam int c_NUM_REGS   = 64;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC  = 2'd2
    } wb_src_t;

    // WAI outranks memRead, so a link-type instruction that also flags a
    // load still writes back the saved PC.
    function automatic wb_src_t wb_src_decode(input logic i_wai, input logic i_mem_read);
        if (i_wai)           return WB_PC;
        else if (i_mem_read) return WB_MEM;
        else                 return WB_ALU;
    endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/regfile.sv
`default_nettype none
// ============================================================================
// Module      : regfile
// Description : 2**ADDR_WIDTH x DATA_WIDTH register array with synchronous
//               active-high reset, one write port and two raw (unbypassed)
//               combinational read ports.
// Ports       : clk, rst          - clock, synchronous reset (clears all)
//               i_we/i_waddr/i_wdata - write port, committed on rising edge
//               i_raddr_a/b       - read indices
//               o_rdata_a/b       - raw array contents at the read indices
// Revision    : 1.0 - initial release
// ============================================================================
module regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr_a,
    input  logic [ADDR_WIDTH-1:0] i_raddr_b,
    output logic [DATA_WIDTH-1:0] o_rdata_a,
    output logic [DATA_WIDTH-1:0] o_rdata_b
);

    localparam int c_DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_regs [0:c_DEPTH-1];

    // Reset wins over a simultaneous write. The address is only used when
    // the write enable is set, so an unknown index on an idle cycle cannot
    // disturb any entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_regs[i_raddr_a];
    assign o_rdata_b = r_regs[i_raddr_b];

endmodule : regfile
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile
// Description : Write-back stage plus general register file. Selects the
//               write-back value (PC / load data / ALU result), commits it
//               to the register file, serves two bypassed read ports and
//               counts committed writes.
// Ports       : clock, reset      - clock, synchronous active-high reset
//               regWrite, WAI, memRead, PC, readData, ALUResult, rd
//                                 - EX/WB buffer outputs
//               rs, rt            - decode-stage read indices
//               out_rsData/out_rtData - read data with write-through bypass
//               out_wbData        - selected write-back value (combinational)
//               wb_count          - committed register write counter
// Revision    : 1.0 - initial release
// ============================================================================
module wb_regfile
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int ADDR_WIDTH = c_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  regWrite,
    input  logic                  WAI,
    input  logic                  memRead,
    input  logic [DATA_WIDTH-1:0] PC,
    input  logic [DATA_WIDTH-1:0] readData,
    input  logic [DATA_WIDTH-1:0] ALUResult,
    input  logic [ADDR_WIDTH-1:0] rd,
    input  logic [ADDR_WIDTH-1:0] rs,
    input  logic [ADDR_WIDTH-1:0] rt,
    output logic [DATA_WIDTH-1:0] out_rsData,
    output logic [DATA_WIDTH-1:0] out_rtData,
    output logic [DATA_WIDTH-1:0] out_wbData,
    output logic [31:0]           wb_count
);

    wb_src_t               w_src;
    logic [DATA_WIDTH-1:0] w_wb_data;
    logic [DATA_WIDTH-1:0] w_raw_rs;
    logic [DATA_WIDTH-1:0] w_raw_rt;
    logic                  w_bypass_rs;
    logic                  w_bypass_rt;
    logic [31:0]           r_wb_count;

    assign w_src = wb_src_decode(WAI, memRead);

    always_comb begin
        w_wb_data = ALUResult;
        case (w_src)
            WB_PC:   w_wb_data = PC;
            WB_MEM:  w_wb_data = readData;
            default: w_wb_data = ALUResult;
        endcase
    end

    regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_regfile (
        .clk       (clock),
        .rst       (reset),
        .i_we      (regWrite),
        .i_waddr   (rd),
        .i_wdata   (w_wb_data),
        .i_raddr_a (rs),
        .i_raddr_b (rt),
        .o_rdata_a (w_raw_rs),
        .o_rdata_b (w_raw_rt)
    );

    // Write-through: a read of the register being written this cycle
    // returns the incoming value instead of the stale array entry.
    assign w_bypass_rs = regWrite && (rs == rd);
    assign w_bypass_rt = regWrite && (rt == rd);

    assign out_rsData = w_bypass_rs ? w_wb_data : w_raw_rs;
    assign out_rtData = w_bypass_rt ? w_wb_data : w_raw_rt;
    assign out_wbData = w_wb_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wb_count <= '0;
        end else if (regWrite) begin
            r_wb_count <= r_wb_count + 32'd1;
        end
    end

    assign wb_count = r_wb_count;

endmodule : wb_regfile
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_regfile
// Description : Self-checking bench for wb_regfile. Inputs change on the
//               falling edge (as the EX/WB buffer does); outputs are sampled
//               1 ns later, well away from the committing rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;

    logic        clock;
    logic        reset;
    logic        regWrite;
    logic        WAI;
    logic        memRead;
    logic [31:0] PC;
    logic [31:0] readData;
    logic [31:0] ALUResult;
    logic [5:0]  rd;
    logic [5:0]  rs;
    logic [5:0]  rt;
    logic [31:0] out_rsData;
    logic [31:0] out_rtData;
    logic [31:0] out_wbData;
    logic [31:0] wb_count;

    int n_cmp = 0;
    int n_err = 0;

    wb_regfile #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (6)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .regWrite   (regWrite),
        .WAI        (WAI),
        .memRead    (memRead),
        .PC         (PC),
        .readData   (readData),
        .ALUResult  (ALUResult),
        .rd         (rd),
        .rs         (rs),
        .rt         (rt),
        .out_rsData (out_rsData),
        .out_rtData (out_rtData),
        .out_wbData (out_wbData),
        .wb_count   (wb_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        we;
        logic        wai;
        logic        mem;
        logic [31:0] pc;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [5:0]  rd;
        logic [5:0]  rs;
        logic [5:0]  rt;
        logic [31:0] exp_rs;
        logic [31:0] exp_rt;
        logic [31:0] exp_wb;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vecs [0:10];

    function automatic vec_t mk(input logic we, input logic wai, input logic mem,
                                input logic [31:0] pc, input logic [31:0] rdata,
                                input logic [31:0] alu, input logic [5:0] d,
                                input logic [5:0] a, input logic [5:0] b,
                                input logic [31:0] ers, input logic [31:0] ert,
                                input logic [31:0] ewb, input logic [31:0] ecnt);
        vec_t v;
        v.we = we; v.wai = wai; v.mem = mem; v.pc = pc; v.rdata = rdata;
        v.alu = alu; v.rd = d; v.rs = a; v.rt = b;
        v.exp_rs = ers; v.exp_rt = ert; v.exp_wb = ewb; v.exp_cnt = ecnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic wai, input logic mem,
                         input logic [31:0] pc, input logic [31:0] rdata,
                         input logic [31:0] alu, input logic [5:0] d,
                         input logic [5:0] a, input logic [5:0] b);
        regWrite = we; WAI = wai; memRead = mem; PC = pc; readData = rdata;
        ALUResult = alu; rd = d; rs = a; rt = b;
    endtask

    initial begin
        // Sequential table: each row is checked before its rising edge, so
        // the array state reflects all earlier rows.
        vecs[0]  = mk(1, 0, 0, 32'h0, 32'h0, 32'h0000_1234, 5, 5, 0,
                      32'h0000_1234, 32'h0, 32'h0000_1234, 0);
        vecs[1]  = mk(0, 0, 0, 32'h0, 32'h0, 32'h0, 5, 5, 5,
                      32'h0000_1234, 32'h0000_1234, 32'h0, 1);
        vecs[2]  = mk(1, 1, 1, 32'hAAAA_0000, 32'h5555_0000, 32'h0F0F_0F0F, 9, 9, 5,
                      32'hAAAA_0000, 32'h0000_1234, 32'hAAAA_0000, 1);
        vecs[3]  = mk(1, 0, 1, 32'hAAAA_0000, 32'h5555_0000, 32'h0F0F_0F0F, 9, 9, 9,
                      32'h5555_0000, 32'h5555_0000, 32'h5555_0000, 2);
        vecs[4]  = mk(0, 0, 0, 32'hAAAA_0000, 32'h5555_0000, 32'hDEAD_BEEF, 9, 9, 5,
                      32'h5555_0000, 32'h0000_1234, 32'hDEAD_BEEF, 3);
        vecs[5]  = mk(0, 1, 1, 32'hAAAA_0000, 32'h5555_0000, 32'hDEAD_BEEF, 9, 9, 9,
                      32'h5555_0000, 32'h5555_0000, 32'hAAAA_0000, 3);
        vecs[6]  = mk(0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 63,
                      32'h0, 32'h0, 32'h0, 3);
        vecs[7]  = mk(1, 0, 0, 32'h0, 32'h0, 32'h0000_CAFE, 0, 0, 1,
                      32'h0000_CAFE, 32'h0, 32'h0000_CAFE, 3);
        vecs[8]  = mk(0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0,
                      32'h0000_CAFE, 32'h0000_CAFE, 32'h0, 4);
        vecs[9]  = mk(1, 0, 0, 32'h0, 32'h0, 32'h0000_0077, 12, 5, 12,
                      32'h0000_1234, 32'h0000_0077, 32'h0000_0077, 4);
        vecs[10] = mk(0, 0, 0, 32'h0, 32'h0, 32'h0, 12, 12, 9,
                      32'h0000_0077, 32'h5555_0000, 32'h0, 5);

        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Pre-fill every register with a nonzero value.
        for (int i = 0; i < 64; i++) begin
            drive(1, 0, 0, 0, 0, 32'h100 + i, i[5:0], 0, 0);
            @(negedge clock);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 check("prefill_count", wb_count, 32'd64);
        rs = 6'd17; rt = 6'd63;
        #1 check("prefill_r17", out_rsData, 32'h111);
        check("prefill_r63", out_rtData, 32'h13F);

        // One-cycle reset, then every register must read back as zero.
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 64; i += 2) begin
            rs = i[5:0];
            rt = 6'(i + 1);
            #1;
            check($sformatf("reset_r%0d", i), out_rsData, 32'h0);
            check($sformatf("reset_r%0d", i + 1), out_rtData, 32'h0);
        end
        check("reset_count", wb_count, 32'h0);

        // Directed table.
        for (int k = 0; k < 11; k++) begin
            @(negedge clock);
            drive(vecs[k].we, vecs[k].wai, vecs[k].mem, vecs[k].pc, vecs[k].rdata,
                  vecs[k].alu, vecs[k].rd, vecs[k].rs, vecs[k].rt);
            #1;
            check($sformatf("vec%0d_rs", k), out_rsData, vecs[k].exp_rs);
            check($sformatf("vec%0d_rt", k), out_rtData, vecs[k].exp_rt);
            check($sformatf("vec%0d_wb", k), out_wbData, vecs[k].exp_wb);
            check($sformatf("vec%0d_cnt", k), wb_count, vecs[k].exp_cnt);
        end

        // Reset colliding with a write: the write is dropped.
        @(negedge clock);
        reset = 1'b1;
        drive(1, 0, 0, 0, 0, 32'd7, 3, 0, 0);
        @(negedge clock);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 3, 3, 12);
        #1;
        check("collide_r3", out_rsData, 32'h0);
        check("collide_r12", out_rtData, 32'h0);
        check("collide_count", wb_count, 32'h0);

        // Counter wrap, with all three indices aimed at r63 during a write.
        @(negedge clock);
        force dut.r_wb_count = 32'hFFFF_FFFE;
        #1 release dut.r_wb_count;
        #1 check("wrap_preload", wb_count, 32'hFFFF_FFFE);
        drive(1, 0, 0, 0, 0, 32'h1, 63, 63, 63);
        #1;
        check("wrap_bypass_rs", out_rsData, 32'h1);
        check("wrap_bypass_rt", out_rtData, 32'h1);
        @(negedge clock);
        drive(1, 0, 0, 0, 0, 32'h2, 10, 63, 10);
        #1;
        check("wrap_count_mid", wb_count, 32'hFFFF_FFFF);
        @(negedge clock);
        drive(0, 0, 0, 0, 0, 0, 0, 63, 10);
        #1;
        check("wrap_count", wb_count, 32'h0);
        check("wrap_r63", out_rsData, 32'h1);
        check("wrap_r10", out_rtData, 32'h2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_wb_regfile
`default_nettype wire
